// File: rtl/md_unit_ctrl_if.sv
// rtl/md_unit_ctrl_if.sv - E-stage multiply/divide unit bus bundle
//
// Purpose: carries the operation request from the pipeline to the MD unit
//          and its status and HI/LO outputs back to the pipeline.
// Signals:
//   Req    pipeline -> unit  CP0 exception/interrupt request for the E-stage instruction
//   MDOp   pipeline -> unit  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
//   A      pipeline -> unit  rs operand (forwarded)
//   B      pipeline -> unit  rt operand (forwarded)
//   Start  unit -> pipeline  combinational, high in the cycle a mult/div is accepted
//   Busy   unit -> pipeline  registered, high while an operation is in flight
//   HI     unit -> pipeline  HI register
//   LO     unit -> pipeline  LO register
// Modports: master = pipeline / hazard side, slave = MD unit.

interface md_unit_ctrl_if;
    logic        Req;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Start;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output Req, MDOp, A, B,
        input  Start, Busy, HI, LO
    );

    modport slave (
        input  Req, MDOp, A, B,
        output Start, Busy, HI, LO
    );
endinterface

// File: rtl/md_unit_ctrl.sv
// rtl/md_unit_ctrl.sv - multiply/divide unit and sequencer with HI/LO ownership
//
// Purpose: executes mult/multu/div/divu with a fixed latency, owns HI/LO,
//          handles mthi/mtlo, and reports Start/Busy to the hazard unit.
//          A CP0 request suppresses all side effects of the E-stage
//          instruction; an operation already in flight always completes.
// Parameters:
//   MULT_CYCLES  busy cycles for mult/multu (>=1)
//   DIV_CYCLES   busy cycles for div/divu (>=1)
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high
//   md     md_unit_ctrl_if.slave (Req, MDOp, A, B in; Start, Busy, HI, LO out)

module md_unit_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic          clk,
    input  logic          reset,
    md_unit_ctrl_if.slave md
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [31:0] r_hi, w_hi_nxt;
    logic [31:0] r_lo, w_lo_nxt;
    logic [31:0] r_pend_hi, w_pend_hi_nxt;
    logic [31:0] r_pend_lo, w_pend_lo_nxt;
    logic        r_pend_wr, w_pend_wr_nxt;
    logic        w_start;

    // ------------------------------------------------------------------
    // Datapath: all results are formed in the accept cycle and parked in
    // the pending register; the busy period only models pipeline latency.
    // ------------------------------------------------------------------
    logic signed [63:0] w_mul_s;
    logic        [63:0] w_mul_u;
    logic               w_div_signed;
    logic               w_a_neg, w_b_neg;
    logic        [31:0] w_a_mag, w_b_mag;
    logic        [31:0] w_dividend, w_divisor;
    logic        [31:0] w_q_mag, w_r_mag;
    logic        [31:0] w_quot, w_rem;
    logic        [63:0] w_result;
    logic               w_is_mult, w_is_div;

    assign w_mul_s = 64'($signed(md.A)) * 64'($signed(md.B));
    assign w_mul_u = {32'd0, md.A} * {32'd0, md.B};

    // Signed divide runs on magnitudes so 0x80000000 / -1 needs no special
    // case: the magnitude 0x80000000 divided by 1, negated, wraps back to
    // 0x80000000 with remainder 0.
    assign w_div_signed = (md.MDOp == OP_DIV);
    assign w_a_neg      = w_div_signed & md.A[31];
    assign w_b_neg      = w_div_signed & md.B[31];
    assign w_a_mag      = w_a_neg ? (32'd0 - md.A) : md.A;
    assign w_b_mag      = w_b_neg ? (32'd0 - md.B) : md.B;
    assign w_dividend   = w_a_mag;
    // Divide-by-zero never commits; a divisor of 1 just keeps the divider defined.
    assign w_divisor    = (md.B == 32'd0) ? 32'd1 : w_b_mag;
    assign w_q_mag      = w_dividend / w_divisor;
    assign w_r_mag      = w_dividend % w_divisor;
    assign w_quot       = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    // Remainder takes the dividend's sign.
    assign w_rem        = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

    assign w_is_mult = (md.MDOp == OP_MULT) || (md.MDOp == OP_MULTU);
    assign w_is_div  = (md.MDOp == OP_DIV)  || (md.MDOp == OP_DIVU);

    always_comb begin
        w_result = {w_rem, w_quot};
        case (md.MDOp)
            OP_MULT:  w_result = w_mul_s;
            OP_MULTU: w_result = w_mul_u;
            default:  w_result = {w_rem, w_quot};
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_wr <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_hi      <= w_hi_nxt;
            r_lo      <= w_lo_nxt;
            r_pend_hi <= w_pend_hi_nxt;
            r_pend_lo <= w_pend_lo_nxt;
            r_pend_wr <= w_pend_wr_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_hi_nxt      = r_hi;
        w_lo_nxt      = r_lo;
        w_pend_hi_nxt = r_pend_hi;
        w_pend_lo_nxt = r_pend_lo;
        w_pend_wr_nxt = r_pend_wr;
        w_start       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // A CP0 request kills every E-stage side effect, including mthi/mtlo.
                if (!md.Req) begin
                    if (w_is_mult || w_is_div) begin
                        w_start       = 1'b1;
                        w_state_nxt   = ST_RUN;
                        w_cnt_nxt     = w_is_mult ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                        w_pend_hi_nxt = w_result[63:32];
                        w_pend_lo_nxt = w_result[31:0];
                        w_pend_wr_nxt = !(w_is_div && (md.B == 32'd0));
                    end else if (md.MDOp == OP_MTHI) begin
                        w_hi_nxt = md.A;
                    end else if (md.MDOp == OP_MTLO) begin
                        w_lo_nxt = md.A;
                    end
                end
            end
            ST_RUN: begin
                // Req is ignored here: the in-flight op belongs to an older,
                // already committed instruction.
                if (r_cnt == CW'(1)) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    if (r_pend_wr) begin
                        w_hi_nxt = r_pend_hi;
                        w_lo_nxt = r_pend_lo;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign md.Start = w_start;
    assign md.Busy  = (r_state == ST_RUN);
    assign md.HI    = r_hi;
    assign md.LO    = r_lo;

    // The hazard unit must hold D while Busy; any MD instruction here is a stall bug.
    a_no_op_while_busy : assert property (
        @(posedge clk) disable iff (reset) (r_state == ST_RUN) |-> (md.MDOp == 3'd0)
    );

endmodule
